// File: rtl/ppu_pkg.sv
// Shared PPU sprite definitions: OAM entry field positions, sprite heights and
// the per-scanline sprite list entry used by the evaluator and pattern fetcher.
package ppu_pkg;

  localparam int unsigned OAM_W       = 64;
  localparam int unsigned TILE_LSB    = 0;
  localparam int unsigned TILE_W      = 10;
  localparam int unsigned PAL_LSB     = 10;
  localparam int unsigned PAL_W       = 4;
  localparam int unsigned HFLIP_BIT   = 14;
  localparam int unsigned VFLIP_BIT   = 15;
  localparam int unsigned Y_LSB       = 32;
  localparam int unsigned Y_FLD_W     = 8;
  localparam int unsigned X_LSB       = 48;
  localparam int unsigned X_W         = 9;
  localparam int unsigned SIZE16_BIT  = 57;
  localparam int unsigned ENABLE_BIT  = 58;
  localparam int unsigned ROW_W       = 4;

  localparam int unsigned SPR_H_SMALL = 8;
  localparam int unsigned SPR_H_LARGE = 16;

  typedef struct packed {
    logic [X_W-1:0]    x;
    logic [TILE_W-1:0] tile;
    logic [PAL_W-1:0]  pal;
    logic              hflip;
    logic [ROW_W-1:0]  row;
  } spr_entry_t;

  localparam int unsigned SPR_ENTRY_W = $bits(spr_entry_t);

endpackage

// File: rtl/ppu_sprite_hit.sv
// Combinational sprite/scanline hit test with pattern-row (vflip) calculation.
// Ports:
//   line   in  Y_W    target scanline
//   entry  in  64     raw OAM entry
//   hit_c  out 1      entry is enabled and covers the scanline
//   info_c out entry  list entry (x, tile, pal, hflip, row) for this sprite
module ppu_sprite_hit
  import ppu_pkg::*;
#(
  parameter int unsigned Y_W = 8
) (
  input  logic [Y_W-1:0]   line,
  input  logic [OAM_W-1:0] entry,
  output logic             hit_c,
  output spr_entry_t       info_c
);

  logic [Y_W-1:0] y;
  logic [Y_W-1:0] row;
  logic [Y_W-1:0] h;
  logic           unused_bits;

  // Modular subtraction lets sprites that start above line 0 (large y) wrap in.
  always_comb begin
    y            = Y_W'(entry[Y_LSB +: Y_FLD_W]);
    h            = entry[SIZE16_BIT] ? Y_W'(SPR_H_LARGE) : Y_W'(SPR_H_SMALL);
    row          = line - y;
    hit_c        = entry[ENABLE_BIT] && (row < h);
    info_c.x     = entry[X_LSB +: X_W];
    info_c.tile  = entry[TILE_LSB +: TILE_W];
    info_c.pal   = entry[PAL_LSB +: PAL_W];
    info_c.hflip = entry[HFLIP_BIT];
    info_c.row   = entry[VFLIP_BIT] ? ROW_W'(h - Y_W'(1) - row) : ROW_W'(row);
  end

  assign unused_bits = ^{entry[31:16], entry[47:40], entry[63:59]};

endmodule

// File: rtl/ppu_sprite_eval.sv
// Per-scanline sprite evaluator: scans OAM one entry per clock and collects the
// first MAX_PER_LINE sprites covering the requested line into a readable list.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start, line           scan request pulse and target scanline
//   busy, done, overflow  scan status
//   oam_re, oam_raddr     OAM read port (data returns one clock later)
//   oam_rdata             OAM entry data
//   list_count            number of valid list entries
//   list_idx              list read index (combinational read)
//   list_x/tile/pal/hflip/row  selected list entry fields
module ppu_sprite_eval
  import ppu_pkg::*;
#(
  parameter int unsigned NUM_SPRITES  = 128,
  parameter int unsigned MAX_PER_LINE = 32,
  parameter int unsigned Y_W          = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [Y_W-1:0]                    line,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow,
  output logic                              oam_re,
  output logic [$clog2(NUM_SPRITES)-1:0]    oam_raddr,
  input  logic [OAM_W-1:0]                  oam_rdata,
  output logic [$clog2(MAX_PER_LINE):0]     list_count,
  input  logic [$clog2(MAX_PER_LINE)-1:0]   list_idx,
  output logic [X_W-1:0]                    list_x,
  output logic [TILE_W-1:0]                 list_tile,
  output logic [PAL_W-1:0]                  list_pal,
  output logic                              list_hflip,
  output logic [ROW_W-1:0]                  list_row
);

  localparam int unsigned AW = $clog2(NUM_SPRITES);
  localparam int unsigned IW = $clog2(MAX_PER_LINE);
  localparam int unsigned CW = IW + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FINISH} state_t;

  state_t         state, next_state;
  logic [Y_W-1:0] line_q;
  logic           re_q;      // a read is still to be issued this cycle
  logic           vld_q;     // oam_rdata holds an entry to evaluate
  logic [AW-1:0]  raddr_q;
  logic [CW-1:0]  count_q;
  logic           overflow_q;
  logic           accept;
  logic           store;
  logic           ovf_hit;
  logic           hit_c;
  spr_entry_t     hit_info;
  spr_entry_t     list_mem [MAX_PER_LINE];
  spr_entry_t     sel;

  ppu_sprite_hit #(.Y_W(Y_W)) u_hit (
    .line   (line_q),
    .entry  (oam_rdata),
    .hit_c  (hit_c),
    .info_c (hit_info)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next state and control decode
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    oam_re     = 1'b0;
    accept     = 1'b0;
    store      = 1'b0;
    ovf_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = S_SCAN;
        end
      end
      S_SCAN: begin
        busy = 1'b1;
        if (vld_q && hit_c) begin
          if (count_q == CW'(MAX_PER_LINE)) ovf_hit = 1'b1;
          else                              store   = 1'b1;
        end
        // Overflow cancels the read issued this cycle; its data is never used.
        oam_re = re_q && !ovf_hit;
        if (ovf_hit || (vld_q && !re_q)) next_state = S_FINISH;
      end
      S_FINISH: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          next_state = S_SCAN;
        end else begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Scan datapath: read pointer, pipeline valid, list count and overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_q     <= '0;
      re_q       <= 1'b0;
      vld_q      <= 1'b0;
      raddr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      line_q     <= line;
      re_q       <= 1'b1;
      vld_q      <= 1'b0;
      raddr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (state == S_SCAN) begin
      vld_q <= oam_re;
      if (oam_re) begin
        if (raddr_q == AW'(NUM_SPRITES - 1)) re_q    <= 1'b0;
        else                                 raddr_q <= raddr_q + AW'(1);
      end
      if (ovf_hit) begin
        re_q       <= 1'b0;
        overflow_q <= 1'b1;
      end
      if (store) count_q <= count_q + CW'(1);
    end
  end

  // List storage, appended in OAM order
  always_ff @(posedge clk) begin
    if (store) list_mem[count_q[IW-1:0]] <= hit_info;
  end

  assign sel        = list_mem[list_idx];
  assign list_x     = sel.x;
  assign list_tile  = sel.tile;
  assign list_pal   = sel.pal;
  assign list_hflip = sel.hflip;
  assign list_row   = sel.row;
  assign oam_raddr  = raddr_q;
  assign list_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ppu_sprite_eval.sv
// Scoreboard bench for ppu_sprite_eval: each start pushes the reference result,
// a negedge monitor checks it when done pulses.
module tb_ppu_sprite_eval;

  localparam int N  = 128;
  localparam int M  = 32;
  localparam int EW = 28;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  line;
  logic        busy, done, overflow, oam_re;
  logic [6:0]  oam_raddr;
  logic [63:0] oam_rdata = '0;
  logic [5:0]  list_count;
  logic [4:0]  list_idx = '0;
  logic [8:0]  list_x;
  logic [9:0]  list_tile;
  logic [3:0]  list_pal;
  logic        list_hflip;
  logic [3:0]  list_row;

  ppu_sprite_eval dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .line       (line),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .oam_re     (oam_re),
    .oam_raddr  (oam_raddr),
    .oam_rdata  (oam_rdata),
    .list_count (list_count),
    .list_idx   (list_idx),
    .list_x     (list_x),
    .list_tile  (list_tile),
    .list_pal   (list_pal),
    .list_hflip (list_hflip),
    .list_row   (list_row)
  );

  always #50 clk = ~clk;

  logic [63:0] oam_mem [N];
  always @(posedge clk) if (oam_re) oam_rdata <= oam_mem[oam_raddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int              cnt;
    bit              ovf;
    int              done_cyc;
    int              reads;
    logic [M*EW-1:0] ents;
  } exp_t;

  exp_t sbq[$];
  exp_t me;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(int tile, int pal, int hf, int vf, int y, int x, int s16, int en);
    logic [63:0] e;
    e = {$urandom, $urandom};
    e[9:0]   = 10'(tile);
    e[13:10] = 4'(pal);
    e[14]    = 1'(hf);
    e[15]    = 1'(vf);
    e[39:32] = 8'(y);
    e[56:48] = 9'(x);
    e[57]    = 1'(s16);
    e[58]    = 1'(en);
    return e;
  endfunction

  // Reference: walk OAM in order applying the scanline rules directly.
  function automatic exp_t model(int ln, int st);
    exp_t r;
    logic [63:0] e;
    int y, h, row;
    r.cnt = 0; r.ovf = 0; r.ents = '0; r.reads = N; r.done_cyc = st + N + 2;
    for (int i = 0; i < N; i++) begin
      e   = oam_mem[i];
      y   = int'(e[39:32]);
      h   = e[57] ? 16 : 8;
      row = (ln - y + 256) % 256;
      if (e[58] && row < h) begin
        if (r.cnt == M) begin
          r.ovf = 1; r.reads = i + 1; r.done_cyc = st + i + 3;
          break;
        end
        r.ents[r.cnt*EW +: EW] = {e[56:48], e[9:0], e[13:10], e[14], 4'(e[15] ? h - 1 - row : row)};
        r.cnt++;
      end
    end
    return r;
  endfunction

  // Monitor: count OAM reads per scan, check results whenever done pulses.
  int reads = 0;
  bit stray = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      reads = 0;
      stray = 0;
    end else begin
      if (oam_re) reads++;
      if (oam_re && !busy) stray = 1;
      if (done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 64'(done), 64'(0));
        end else begin
          me = sbq.pop_front();
          check("done_cycle", 64'(cyc), 64'(me.done_cyc));
          check("list_count", 64'(list_count), 64'(me.cnt));
          check("overflow", 64'(overflow), 64'(me.ovf));
          check("oam_reads", 64'(reads), 64'(me.reads));
          check("stray_oam_re", 64'(stray), 64'(0));
          for (int i = 0; i < me.cnt; i++) begin
            list_idx = 5'(i);
            #1;
            check($sformatf("list[%0d]", i),
                  64'({list_x, list_tile, list_pal, list_hflip, list_row}),
                  64'(me.ents[i*EW +: EW]));
          end
        end
        reads = 0;
        stray = 0;
      end
    end
  end

  // Called at a negedge: start is high for the current cycle.
  task automatic launch(input int ln);
    line  = 8'(ln);
    start = 1'b1;
    sbq.push_back(model(ln, cyc));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    if (!done) begin
      check("done_timeout", 64'(done), 64'(1));
      sbq.delete();
    end
  endtask

  task automatic clear_oam();
    for (int i = 0; i < N; i++) oam_mem[i] = mk(i, 0, 0, 0, $urandom, i, 0, 0);
  endtask

  task automatic rand_oam(input int ln);
    int p;
    p = int'($urandom_range(10, 60));
    for (int i = 0; i < N; i++) begin
      int y;
      y = (int'($urandom_range(0, 99)) < p) ? (ln - int'($urandom_range(0, 17)) + 256) % 256
                                              : int'($urandom_range(0, 255));
      oam_mem[i] = mk($urandom, $urandom, $urandom, $urandom, y, $urandom, $urandom,
                      int'($urandom_range(0, 3) != 0));
    end
  endtask

  initial begin
    #(100 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ln;
    reset_n = 1'b0;
    start   = 1'b0;
    line    = '0;
    clear_oam();
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_oam_re", 64'(oam_re), 64'(0));
    check("rst_oam_raddr", 64'(oam_raddr), 64'(0));
    check("rst_list_count", 64'(list_count), 64'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic size-8 hit, then vflip on a 16-row sprite
    oam_mem[0] = mk(5, 3, 0, 0, 10, 100, 0, 1);
    launch(12); wait_done(); repeat (3) @(negedge clk);
    oam_mem[0] = mk(5, 3, 1, 1, 10, 100, 1, 1);
    launch(12); wait_done(); repeat (3) @(negedge clk);

    // Wrap past the top, then the same sprite disabled
    oam_mem[0] = mk(77, 9, 0, 0, 250, 300, 1, 1);
    launch(3); wait_done(); repeat (3) @(negedge clk);
    oam_mem[0] = mk(77, 9, 0, 0, 250, 300, 1, 0);
    launch(3); wait_done(); repeat (3) @(negedge clk);

    // Overflow: 40 sprites on line 0
    clear_oam();
    for (int i = 0; i < 40; i++) oam_mem[i] = mk(i + 100, i, i % 2, 0, 0, i + 200, 0, 1);
    launch(0); wait_done(); repeat (3) @(negedge clk);

    // Start while busy is ignored; start on the done cycle restarts
    ln = int'($urandom_range(0, 255));
    rand_oam(ln);
    launch(ln);
    repeat (4) @(negedge clk);
    line = 8'(ln + 40); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    launch(ln + 100);
    wait_done(); repeat (3) @(negedge clk);

    // Reset in the middle of a scan
    ln = int'($urandom_range(0, 255));
    rand_oam(ln);
    launch(ln);
    repeat (20) @(negedge clk);
    #10 reset_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_oam_re", 64'(oam_re), 64'(0));
    check("midrst_list_count", 64'(list_count), 64'(0));
    check("midrst_overflow", 64'(overflow), 64'(0));
    sbq.delete();
    @(negedge clk);
    #10 reset_n = 1'b1;
    @(negedge clk);
    launch(ln); wait_done(); repeat (3) @(negedge clk);

    // Randomized scans
    for (int t = 0; t < 10; t++) begin
      ln = int'($urandom_range(0, 255));
      rand_oam(ln);
      launch(ln); wait_done();
      repeat (int'($urandom_range(1, 4))) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
